// File: rtl/instr_fetch_unit.sv
// ============================================================================
//  Module   : instr_fetch_unit
//  Brief    : Fetch stage. Owns the fetch address, issues one outstanding
//             word-aligned request at a time to instruction memory, buffers
//             returned words in a small FIFO and hands (pc, instr) to decode.
//             Branch/jump redirects flush the buffer and drop any stale
//             in-flight response.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] next_pc
);

    localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]  C_DEPTH = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;  // no request outstanding
    localparam logic [1:0] S_WAIT = 2'd1;  // waiting for a live response
    localparam logic [1:0] S_DROP = 2'd2;  // waiting for a stale response

    logic [1:0]    r_state;
    logic [31:0]   r_fetch_addr;
    logic [31:0]   r_req_pc;
    logic [CW-1:0] r_count;
    logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
    logic [31:0]   r_fifo_instr [FIFO_DEPTH];

    logic          w_credit;
    logic          w_req_valid;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_wr_idx;
    logic          w_unused;

    // Credit only counts registered occupancy, so if_ready never reaches
    // imem_req_valid combinationally. Reset and redirect both mask the request.
    assign w_credit    = (r_count < C_DEPTH);
    assign w_req_valid = reset_n && !redirect_valid && (r_state == S_IDLE) && w_credit;
    assign w_accept    = w_req_valid && imem_req_ready;
    assign w_push      = (r_state == S_WAIT) && imem_rsp_valid;
    assign w_pop       = (r_count != '0) && if_ready;
    assign w_wr_idx    = r_count - {{(CW-1){1'b0}}, w_pop};

    // Low address bits of a redirect target are ignored by design.
    assign w_unused    = ^redirect_pc[1:0];

    // Fetch-address register and request/response state machine.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_fetch_addr <= RESET_PC;
            r_req_pc     <= 32'h0;
        end else if (redirect_valid) begin
            r_fetch_addr <= {redirect_pc[31:2], 2'b00};
            case (r_state)
                S_WAIT, S_DROP: r_state <= imem_rsp_valid ? S_IDLE : S_DROP;
                default:        r_state <= S_IDLE;
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req_pc     <= r_fetch_addr;
                        r_fetch_addr <= r_fetch_addr + 32'd4;
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT, S_DROP: begin
                    if (imem_rsp_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Shifting instruction buffer: entry 0 is always the registered head.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_pc[i]    <= 32'h0;
                r_fifo_instr[i] <= 32'h0;
            end
        end else if (redirect_valid) begin
            r_count <= '0;
        end else begin
            if (w_pop) begin
                for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                    r_fifo_pc[i]    <= r_fifo_pc[i+1];
                    r_fifo_instr[i] <= r_fifo_instr[i+1];
                end
            end
            // A push lands after the shift, so it overrides the shifted value.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (w_push && (w_wr_idx == CW'(i))) begin
                    r_fifo_pc[i]    <= r_req_pc;
                    r_fifo_instr[i] <= imem_rsp_data;
                end
            end
            r_count <= r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_addr;
    assign if_valid       = (r_count != '0);
    assign if_pc          = r_fifo_pc[0];
    assign if_instr       = r_fifo_instr[0];
    assign next_pc        = r_fetch_addr;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
//  Module   : tb_instr_fetch_unit
//  Brief    : Self-checking bench for instr_fetch_unit: a directed vector
//             table for fall-through and back-pressure, hand sequences for
//             redirect/reset corners, and a randomized run against a
//             queue-based reference model with a variable-latency memory.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;

    logic        clk;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] next_pc;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .next_pc        (next_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instruction memory content: a fixed scramble of the address.
    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst;
        bit          rrdy;
        bit          rspv;
        logic [31:0] rspd;
        bit          ifr;
        bit          e_rv;
        logic [31:0] e_ra;
        bit          e_iv;
        bit          e_hd;
        logic [31:0] e_pc;
        logic [31:0] e_in;
        logic [31:0] e_np;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    // ---------------- reference model + memory ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        m_q [$];
    logic [31:0] m_next = RESET_PC;
    logic [31:0] m_tag  = 32'h0;
    bit          m_out   = 1'b0;
    bit          m_stale = 1'b0;
    bit          m_valid = 1'b0;

    bit          mem_busy = 1'b0;
    int          mem_lat  = 0;
    logic [31:0] mem_addr = 32'h0;
    int          lat_lo   = 0;
    int          lat_hi   = 0;

    bit          s_req_valid;
    logic [31:0] s_req_addr;
    bit          s_if_valid;
    logic [31:0] s_if_pc;
    logic [31:0] s_next_pc;

    // One clock cycle: drive at posedge+1, check at negedge, update at posedge.
    task automatic tick(input bit rn, input bit rd, input logic [31:0] rp,
                        input bit rr, input bit ir);
        bit exp_req, acc_dut, pop_m, rsp;
        reset_n        = rn;
        redirect_valid = rd;
        redirect_pc    = rp;
        imem_req_ready = rr;
        if_ready       = ir;
        rsp            = mem_busy && (mem_lat == 0);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? dat(mem_addr) : $urandom;
        @(negedge clk);
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_if_valid  = if_valid;
        s_if_pc     = if_pc;
        s_next_pc   = next_pc;
        exp_req = rn && !rd && !m_out && (m_q.size() < FIFO_DEPTH);
        if (m_valid) begin
            chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
            if (exp_req) chk("req_addr", imem_req_addr, m_next);
            chk("next_pc", next_pc, m_next);
            chk("if_valid", {31'b0, if_valid}, {31'b0, (m_q.size() != 0)});
            if (m_q.size() != 0) begin
                chk("if_pc", if_pc, m_q[0].pc);
                chk("if_instr", if_instr, m_q[0].ins);
            end
        end
        acc_dut = imem_req_valid && rr;
        pop_m   = ir && (m_q.size() != 0);
        @(posedge clk);
        #1;
        if (rsp) mem_busy = 1'b0;
        else if (mem_busy) mem_lat--;
        if (acc_dut) begin
            mem_busy = 1'b1;
            mem_addr = s_req_addr;
            mem_lat  = int'($urandom_range(lat_hi, lat_lo));
        end
        if (!rn) begin
            m_q.delete();
            m_out   = 1'b0;
            m_stale = 1'b0;
            m_next  = RESET_PC;
            m_valid = 1'b1;
        end else if (rd) begin
            m_q.delete();
            m_next = {rp[31:2], 2'b00};
            if (m_out) begin
                if (rsp) m_out = 1'b0;
                else     m_stale = 1'b1;
            end
        end else begin
            if (pop_m) void'(m_q.pop_front());
            if (rsp && m_out) begin
                if (!m_stale) m_q.push_back('{m_tag, dat(m_tag)});
                m_out   = 1'b0;
                m_stale = 1'b0;
            end
            if (exp_req && rr) begin
                m_out   = 1'b1;
                m_stale = 1'b0;
                m_tag   = m_next;
                m_next  = m_next + 32'd4;
            end
        end
    endtask

    // Reset, holding it until the memory has delivered anything in flight.
    task automatic do_reset();
        int g;
        g = 0;
        while (mem_busy && g < 20) begin
            tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            g++;
        end
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Run with ready memory/decode until if_valid is seen; report the head pc.
    task automatic run_to_valid(input string nm, input logic [31:0] exp_pc);
        int g;
        g = 0;
        s_if_valid = 1'b0;
        while (!s_if_valid && g < 20) begin
            tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            g++;
        end
        chk({nm, "_seen"}, {31'b0, s_if_valid}, 32'h1);
        chk({nm, "_pc"}, s_if_pc, exp_pc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] got [$];
        int          g;

        vecs[0]  = '{0,0,0,32'h0,0,       0,32'h0,   0,1,32'h0,32'h0,        32'h0};
        vecs[1]  = '{0,0,0,32'h0,0,       0,32'h0,   0,1,32'h0,32'h0,        32'h0};
        vecs[2]  = '{1,1,0,32'h0,1,       1,32'h0,   0,0,32'h0,32'h0,        32'h0};
        vecs[3]  = '{1,1,1,dat(32'h0),1,  0,32'h0,   0,0,32'h0,32'h0,        32'h4};
        vecs[4]  = '{1,1,0,32'h0,1,       1,32'h4,   1,1,32'h0,dat(32'h0),   32'h4};
        vecs[5]  = '{1,1,1,dat(32'h4),1,  0,32'h0,   0,0,32'h0,32'h0,        32'h8};
        vecs[6]  = '{1,1,0,32'h0,1,       1,32'h8,   1,1,32'h4,dat(32'h4),   32'h8};
        vecs[7]  = '{1,1,1,dat(32'h8),1,  0,32'h0,   0,0,32'h0,32'h0,        32'hC};
        vecs[8]  = '{1,1,0,32'h0,0,       1,32'hC,   1,1,32'h8,dat(32'h8),   32'hC};
        vecs[9]  = '{1,1,1,dat(32'hC),0,  0,32'h0,   1,1,32'h8,dat(32'h8),   32'h10};
        vecs[10] = '{1,1,0,32'h0,0,       0,32'h0,   1,1,32'h8,dat(32'h8),   32'h10};
        vecs[11] = '{1,1,0,32'h0,0,       0,32'h0,   1,1,32'h8,dat(32'h8),   32'h10};
        vecs[12] = '{1,1,0,32'h0,1,       0,32'h0,   1,1,32'h8,dat(32'h8),   32'h10};
        vecs[13] = '{1,1,0,32'h0,1,       1,32'h10,  1,1,32'hC,dat(32'hC),   32'h10};
        vecs[14] = '{1,1,1,dat(32'h10),1, 0,32'h0,   0,0,32'h0,32'h0,        32'h14};
        vecs[15] = '{1,1,0,32'h0,1,       1,32'h14,  1,1,32'h10,dat(32'h10), 32'h14};

        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if_ready       = 1'b0;
        @(posedge clk);
        #1;

        // Fall-through with 1-cycle memory, then decode back-pressure.
        for (int i = 0; i < NV; i++) begin
            reset_n        = vecs[i].rst;
            imem_req_ready = vecs[i].rrdy;
            imem_rsp_valid = vecs[i].rspv;
            imem_rsp_data  = vecs[i].rspd;
            if_ready       = vecs[i].ifr;
            @(negedge clk);
            chk($sformatf("v%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].e_rv});
            if (vecs[i].e_rv) chk($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].e_ra);
            chk($sformatf("v%0d_if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].e_iv});
            if (vecs[i].e_hd) begin
                chk($sformatf("v%0d_if_pc", i), if_pc, vecs[i].e_pc);
                chk($sformatf("v%0d_if_instr", i), if_instr, vecs[i].e_in);
            end
            chk($sformatf("v%0d_next_pc", i), next_pc, vecs[i].e_np);
            @(posedge clk);
            #1;
        end
        imem_rsp_valid = 1'b0;

        // Redirect while waiting: in-flight response is dropped.
        do_reset();
        lat_lo = 2; lat_hi = 2;
        tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("wait_first_addr", s_req_addr, 32'h0);
        tick(1'b1, 1'b1, 32'h0040_0013, 1'b1, 1'b1);
        chk("wait_redir_req", {31'b0, s_req_valid}, 32'h0);
        tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("wait_redir_npc", s_next_pc, 32'h0040_0010);
        chk("drop_no_req", {31'b0, s_req_valid}, 32'h0);
        g = 0;
        s_req_valid = 1'b0;
        while (!s_req_valid && g < 10) begin
            tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            chk("drop_if_empty", {31'b0, s_if_valid}, 32'h0);
            g++;
        end
        chk("target_req_addr", s_req_addr, 32'h0040_0010);
        run_to_valid("target_head", 32'h0040_0010);

        // Redirect together with a response and a pop: nothing survives.
        do_reset();
        lat_lo = 0; lat_hi = 0;
        tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("pre_redir_head", s_if_pc, 32'h0);
        tick(1'b1, 1'b1, 32'h0000_0080, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("flush_if_valid", {31'b0, s_if_valid}, 32'h0);
        chk("flush_req_valid", {31'b0, s_req_valid}, 32'h1);
        chk("flush_req_addr", s_req_addr, 32'h0000_0080);

        // Redirect to the top word: address wraps to zero.
        do_reset();
        tick(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        chk("idle_redir_req", {31'b0, s_req_valid}, 32'h0);
        g = 0;
        while (got.size() < 2 && g < 20) begin
            tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            if (s_req_valid) got.push_back(s_req_addr);
            g++;
        end
        chk("wrap_count", got.size(), 32'd2);
        if (got.size() == 2) begin
            chk("wrap_addr0", got[0], 32'hFFFF_FFFC);
            chk("wrap_addr1", got[1], 32'h0000_0000);
        end

        // Reset during a wait, response arrives while reset is held.
        do_reset();
        lat_lo = 1; lat_hi = 1;
        tick(1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("pre_rst_addr", s_req_addr, 32'h0000_0100);
        tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("rst_req_masked", {31'b0, s_req_valid}, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("post_rst_req", {31'b0, s_req_valid}, 32'h1);
        chk("post_rst_addr", s_req_addr, RESET_PC);
        chk("post_rst_empty", {31'b0, s_if_valid}, 32'h0);
        run_to_valid("post_rst_head", RESET_PC);

        // Randomized traffic against the reference model.
        do_reset();
        lat_lo = 0; lat_hi = 3;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(299, 0) == 0) begin
                do_reset();
            end else begin
                tick(1'b1, ($urandom_range(9, 0) == 0), $urandom,
                     ($urandom_range(9, 0) < 7), ($urandom_range(9, 0) < 6));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of program_counter.
- Owns the architectural fetch address and issues word-aligned requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions in a small FIFO and presents (pc, instr) pairs to decode with valid/ready.
- Supports branch/jump redirect with flush; exports next_pc for the PC register.

Parameters:
- RESET_PC, 32'h00000000, fetch address loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, 2..8).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  32  target address; bits [1:0] ignored (treated as 0).
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_req_ready  input  1  memory accepts request.
- imem_rsp_valid  input  1  instruction data returned (always accepted).
- imem_rsp_data  input  32  instruction word.
- if_valid  output  1  FIFO head valid to decode.
- if_ready  input  1  decode consumes head.
- if_pc  output  32  PC of head instruction.
- if_instr  output  32  head instruction.
- next_pc  output  32  current fetch address, for program_counter.

Behaviour:
- Reset (reset_n=0 at posedge):
  - fetch_addr=RESET_PC; FIFO emptied; state=S_IDLE.
  - imem_req_valid=0, if_valid=0, if_pc=0, if_instr=0, next_pc=RESET_PC.
  - Reset applied mid-transaction discards any pending response; a response arriving while reset_n=0 is ignored.
- Memory protocol: at most one outstanding request; response latency ≥1 cycle, unbounded.
- States:
  - S_IDLE: no outstanding request. If credit available (fifo_count + 0 < FIFO_DEPTH), assert imem_req_valid with imem_req_addr=fetch_addr. On req_valid && req_ready: latch req_pc=fetch_addr, fetch_addr+=4 (wraps 32'hFFFFFFFC→0), go to S_WAIT.
  - S_WAIT: imem_req_valid=0. On rsp_valid: push {req_pc, rsp_data} to FIFO, go to S_IDLE.
  - S_DROP: outstanding response is stale. On rsp_valid: discard it, go to S_IDLE.
- Credit: a request is issued only if a FIFO slot is guaranteed. A pop in the same cycle does not count toward credit, so there is no combinational if_ready→imem_req_valid path.
- FIFO rules:
  - Push and pop in the same cycle keep count unchanged.
  - Pop occurs only when if_valid && if_ready.
  - if_pc/if_instr are registered FIFO head outputs and hold stable while if_valid && !if_ready.
- Redirect (redirect_valid=1), highest priority after reset:
  - FIFO flushed (if_valid=0 next cycle); a same-cycle pop and push are both ignored.
  - fetch_addr={redirect_pc[31:2],2'b00}.
  - S_WAIT → S_DROP (a response arriving that same cycle is also dropped, go to S_IDLE). S_DROP stays in S_DROP unless a response arrives that cycle. S_IDLE stays in S_IDLE.
  - If S_IDLE is presenting a request in the redirect cycle, imem_req_valid is deasserted combinationally. The request is not issued and fetch_addr is not incremented; the first request to the target occurs the next cycle.
  - Back-to-back redirects: the last one wins.
- next_pc equals the registered fetch_addr. Fall-through throughput is 1 instruction per 2 cycles (one outstanding request).

Test Plan:
- Reset then free-running, always-ready memory with 1-cycle latency, if_ready=1 → requests to 0x0,0x4,0x8,…; if_pc sequence 0x0,0x4,0x8 with matching data; next_pc=0x4 after first accept.
- Hold if_ready=0 → FIFO fills to 2 entries, imem_req_valid stays 0, if_pc=0x0 stable. Release → drains 0x0,0x4, then fetching resumes at 0x8.
- Redirect to 0x00400013 while in S_WAIT → in-flight response dropped, FIFO empty, next request addr=0x00400010, first if_pc=0x00400010.
- Redirect in the same cycle as rsp_valid and if_ready=1 → neither pushed nor popped; if_valid=0 next cycle; next request at target.
- Redirect to 0xFFFFFFFC → fetches 0xFFFFFFFC then 0x00000000.
- reset_n=0 asserted in S_WAIT, response arrives during reset → ignored; after release, first request addr=RESET_PC, if_valid=0 until its response.
